// File: rtl/axi_st_d256_rx_credit_slave.sv
// Receive-side endpoint for the 256-bit AXI-ST logic-link channel.
// Buffers pushed words in a local FIFO and presents them to the user as AXI-ST.
// Returns one flow-control credit per popped word, after an initial grant of
// DEPTH credits at link-up.
//
// state  | meaning
// S_DOWN | link not up: FIFO flushed, no credits, pushes ignored
// S_UP   | link up: FIFO active, credits drained onto tx_st_credit
module axi_st_d256_rx_credit_slave #(
  parameter int WIDTH    = 256,
  parameter int DEPTH    = 128,
  parameter int CRED_MAX = 15
) (
  input  logic             clk_wr,
  input  logic             rst_wr_n,
  input  logic             tx_online,
  input  logic             rx_online,
  input  logic             rx_st_pushbit,
  input  logic [WIDTH-1:0] rx_st_data,
  output logic [3:0]       tx_st_credit,
  output logic [WIDTH-1:0] user_tdata,
  output logic             user_tvalid,
  input  logic             user_tready,
  output logic [31:0]      rx_st_debug_status
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = AW + 1;

  typedef enum logic {
    S_DOWN = 1'b0,
    S_UP   = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [OW-1:0]    pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       credit_q, credit_d;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             link_up;
  logic             is_up;
  logic             full;
  logic             pop;
  logic             push_acc;
  logic [3:0]       emit;

  assign link_up  = tx_online & rx_online;
  assign is_up    = (state_q == S_UP);
  assign full     = (occ_q == OW'(DEPTH));
  // occupancy is forced to zero while down, so valid needs no state qualifier
  assign pop      = user_tvalid & user_tready;
  assign push_acc = is_up & link_up & rx_st_pushbit & (~full | pop);

  assign user_tvalid  = (occ_q != '0);
  // gate the read so the output is zero whenever nothing valid is held
  assign user_tdata   = user_tvalid ? mem[rd_ptr_q] : '0;
  assign tx_st_credit = credit_q;
  assign rx_st_debug_status = {ovf_q, is_up, 14'd0, 8'(occ_q), 8'(pend_q)};

  // credits released this cycle: min(pending, CRED_MAX)
  always_comb begin
    emit = 4'(CRED_MAX);
    if (32'(pend_q) < CRED_MAX) emit = 4'(pend_q);
  end

  // next-state for link FSM, FIFO pointers, occupancy and credit accounting
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    pend_d   = pend_q;
    credit_d = 4'd0;
    ovf_d    = ovf_q;

    // the sticky survives link drops; only reset clears it
    if (is_up && link_up && rx_st_pushbit && full && !pop) ovf_d = 1'b1;

    case (state_q)
      S_DOWN: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        occ_d    = '0;
        pend_d   = '0;
        if (link_up) begin
          state_d = S_UP;
          pend_d  = OW'(DEPTH);
        end
      end
      S_UP: begin
        if (!link_up) begin
          state_d  = S_DOWN;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          occ_d    = '0;
          pend_d   = '0;
        end else begin
          if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
          if (pop)      rd_ptr_d = rd_ptr_q + AW'(1);
          occ_d    = occ_q + OW'(push_acc) - OW'(pop);
          credit_d = emit;
          // a popped credit joins pending now and leaves no earlier than next cycle
          pend_d   = pend_q - OW'(emit) + OW'(pop);
        end
      end
      default: state_d = S_DOWN;
    endcase
  end

  // control and status registers
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_q  <= S_DOWN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      credit_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      credit_q <= credit_d;
    end
  end

  // FIFO storage; contents are don't-care once pointers/occupancy are cleared
  always_ff @(posedge clk_wr) begin
    if (push_acc) mem[wr_ptr_q] <= rx_st_data;
  end

endmodule
